// File: rtl/mandel_writer.sv
// Escape-time Mandelbrot renderer: walks a WIDTH x HEIGHT frame in raster order, one z<-z^2+c step per clock,
// and writes one colour index per pixel through a valid/ready port; w_we is held until w_ready accepts.
module mandel_writer #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 200,
    parameter int MAXITER = 64,
    parameter int X0      = -10240,
    parameter int Y0      = -5120,
    parameter int DX      = 45,
    parameter int DY      = 51
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] w_addr,
    output logic [7:0]  w_data,
    output logic        w_we,
    input  logic        w_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ITER  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0]        X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0]        Y_LAST = 16'(HEIGHT - 1);
    localparam logic [7:0]         MAX_IT = 8'(MAXITER);
    localparam logic signed [15:0] CX0    = 16'(X0);
    localparam logic signed [15:0] CY0    = 16'(Y0);
    localparam logic signed [15:0] STEP_X = 16'(DX);
    localparam logic signed [15:0] STEP_Y = 16'(DY);
    localparam logic [16:0]        ESC_LIM = 17'd16384;

    state_t state, state_nxt;

    logic [15:0]        x, y;
    logic signed [15:0] cx, cy, zx, zy;
    logic [7:0]         iter;

    logic signed [31:0] pxx, pyy, pxy;
    logic [15:0]        zx2, zy2;
    logic signed [15:0] zxy;
    logic [16:0]        mag;
    logic               escape, max_hit, stop_iter, accept, row_end, last_pix;

    // Q4.12 x Q4.12 gives Q8.24; the >>>12 keeps bits [27:12] after truncation
    always_comb begin
        pxx       = 32'(zx) * 32'(zx);
        pyy       = 32'(zy) * 32'(zy);
        pxy       = 32'(zx) * 32'(zy);
        zx2       = 16'(pxx >>> 12);
        zy2       = 16'(pyy >>> 12);
        zxy       = 16'(pxy >>> 12);
        mag       = {1'b0, zx2} + {1'b0, zy2};
        escape    = (mag >= ESC_LIM);
        max_hit   = (iter == MAX_IT);
        stop_iter = escape || max_hit;
        row_end   = (x == X_LAST);
        last_pix  = row_end && (y == Y_LAST);
        accept    = (state == WRITE) && w_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        w_we      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                state_nxt = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (stop_iter) state_nxt = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                w_we = 1'b1;
                if (w_ready) state_nxt = last_pix ? DONE : INIT;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = INIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            cx     <= '0;
            cy     <= '0;
            zx     <= '0;
            zy     <= '0;
            iter   <= '0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x      <= '0;
                        y      <= '0;
                        w_addr <= '0;
                        cx     <= CX0;
                        cy     <= CY0;
                    end
                end
                INIT: begin
                    zx   <= '0;
                    zy   <= '0;
                    iter <= '0;
                end
                ITER: begin
                    if (stop_iter) begin
                        w_data <= max_hit ? 8'd0 : iter;
                    end else begin
                        zx   <= zx2 - zy2 + cx;
                        zy   <= (zxy <<< 1) + cy;
                        iter <= iter + 8'd1;
                    end
                end
                WRITE: begin
                    // address stays on the last pixel once the frame is finished
                    if (accept && !last_pix) begin
                        w_addr <= w_addr + 16'd1;
                        if (row_end) begin
                            x  <= '0;
                            cx <= CX0;
                            y  <= y + 16'd1;
                            cy <= cy + STEP_Y;
                        end else begin
                            x  <= x + 16'd1;
                            cx <= cx + STEP_X;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_writer.sv
// Scoreboard bench for mandel_writer: three instances (default frame, 2x1 with c=0, 4x3 frame).
module tb_mandel_writer;

    localparam int X0 = -10240;
    localparam int Y0 = -5120;
    localparam int DX = 45;
    localparam int DY = 51;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 0, ready_a = 0, busy_a, done_a, we_a;
    logic [15:0] addr_a;
    logic [7:0]  data_a;
    logic start_b = 0, ready_b = 0, busy_b, done_b, we_b;
    logic [15:0] addr_b;
    logic [7:0]  data_b;
    logic start_c = 0, ready_c = 0, busy_c, done_c, we_c;
    logic [15:0] addr_c;
    logic [7:0]  data_c;

    int n_cmp = 0;
    int n_bad = 0;
    wr_t sb_q[$];

    mandel_writer dut_a (
        .clock(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .w_addr(addr_a), .w_data(data_a), .w_we(we_a), .w_ready(ready_a)
    );

    mandel_writer #(.WIDTH(2), .HEIGHT(1), .MAXITER(16), .X0(0), .Y0(0), .DX(0), .DY(0)) dut_b (
        .clock(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .w_addr(addr_b), .w_data(data_b), .w_we(we_b), .w_ready(ready_b)
    );

    mandel_writer #(.WIDTH(4), .HEIGHT(3)) dut_c (
        .clock(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .w_addr(addr_c), .w_data(data_c), .w_we(we_c), .w_ready(ready_c)
    );

    // Reference escape-time count: 0 if MAXITER reached, else number of updates before escape
    function automatic logic [7:0] model_pix(input logic [15:0] cx, input logic [15:0] cy, input int maxit);
        logic [15:0] zx = 16'd0;
        logic [15:0] zy = 16'd0;
        logic [15:0] zx2, zy2, zxy;
        int pxx, pyy, pxy;
        for (int i = 0; i <= maxit; i++) begin
            if (i == maxit) return 8'd0;
            pxx = int'($signed(zx)) * int'($signed(zx));
            pyy = int'($signed(zy)) * int'($signed(zy));
            pxy = int'($signed(zx)) * int'($signed(zy));
            zx2 = pxx[27:12];
            zy2 = pyy[27:12];
            zxy = pxy[27:12];
            if (({1'b0, zx2} + {1'b0, zy2}) >= 17'd16384) return 8'(i);
            zx = zx2 - zy2 + cx;
            zy = {zxy[14:0], 1'b0} + cy;
        end
        return 8'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        start_a = 0; start_b = 0; start_c = 0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        n_cmp++; if (we_a !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", we_a); end
        n_cmp++; if (addr_a !== 16'd0) begin n_bad++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
        n_cmp++; if (data_a !== 8'd0) begin n_bad++; $display("FAIL reset_data got=%0d exp=0", data_a); end
        reset = 1'b0;
    endtask

    task automatic test_first_write();
        wr_t e;
        int got = 0;
        sb_q.delete();
        ready_a = 1'b1;
        sb_q.push_back('{addr: 16'd0, data: 8'd1});
        sb_q.push_back('{addr: 16'd1, data: model_pix(16'(X0 + DX), 16'(Y0), 64)});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL first_busy_edge1 got=%b exp=1", busy_a); end
        tick(); tick();
        n_cmp++; if (we_a !== 1'b0) begin n_bad++; $display("FAIL first_we_edge3 got=%b exp=0", we_a); end
        tick();
        n_cmp++; if (we_a !== 1'b1) begin n_bad++; $display("FAIL first_we_edge4 got=%b exp=1", we_a); end
        for (int cyc = 0; cyc < 500 && got < 2; cyc++) begin
            if (we_a && ready_a) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (addr_a !== e.addr || data_a !== e.data) begin
                    n_bad++;
                    $display("FAIL first_write%0d got=%0d/%0d exp=%0d/%0d", got, addr_a, data_a, e.addr, e.data);
                end
                got++;
            end
            tick();
        end
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL first_timeout got=%0d writes exp=2", got); end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        n_cmp++; if (we_a !== 1'b1) begin n_bad++; $display("FAIL bp_we_start got=%b exp=1", we_a); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (we_a !== 1'b1 || addr_a !== 16'd0 || data_a !== 8'd1) begin
                n_bad++;
                $display("FAIL bp_hold%0d got we=%b addr=%0d data=%0d exp we=1 addr=0 data=1", i, we_a, addr_a, data_a);
            end
        end
        ready_a = 1'b1;
        tick();
        n_cmp++;
        if (we_a !== 1'b0 || busy_a !== 1'b1 || addr_a !== 16'd1) begin
            n_bad++;
            $display("FAIL bp_accept got we=%b busy=%b addr=%0d exp we=0 busy=1 addr=1", we_a, busy_a, addr_a);
        end
    endtask

    task automatic test_zero_c();
        wr_t e;
        int cyc = 0;
        int n = 0;
        int acc_t[2];
        do_reset(2);
        sb_q.delete();
        ready_b = 1'b1;
        sb_q.push_back('{addr: 16'd0, data: 8'd0});
        sb_q.push_back('{addr: 16'd1, data: 8'd0});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n_cmp++; if (busy_b !== 1'b1) begin n_bad++; $display("FAIL zc_busy got=%b exp=1", busy_b); end
        while (!done_b && cyc < 300) begin
            if (we_b && ready_b) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL zc_extra_write got addr=%0d exp none", addr_b);
                end else begin
                    e = sb_q.pop_front();
                    if (addr_b !== e.addr || data_b !== e.data) begin
                        n_bad++;
                        $display("FAIL zc_write got=%0d/%0d exp=%0d/%0d", addr_b, data_b, e.addr, e.data);
                    end
                end
                if (n < 2) acc_t[n] = cyc;
                n++;
            end
            tick();
            cyc++;
        end
        n_cmp++; if (cyc != 38) begin n_bad++; $display("FAIL zc_done_latency got=%0d exp=38", cyc); end
        n_cmp++; if (n != 2) begin n_bad++; $display("FAIL zc_writes got=%0d exp=2", n); end
        if (n >= 2) begin
            n_cmp++;
            if (acc_t[1] - acc_t[0] != 19) begin
                n_bad++;
                $display("FAIL zc_pixel_cycles got=%0d exp=19", acc_t[1] - acc_t[0]);
            end
        end
        n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL zc_busy_end got=%b exp=0", busy_b); end
    endtask

    task automatic test_frame();
        wr_t e;
        int cyc = 0;
        int n = 0;
        do_reset(2);
        sb_q.delete();
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 4; xx++)
                sb_q.push_back('{addr: 16'(yy * 4 + xx),
                                 data: model_pix(16'(X0 + xx * DX), 16'(Y0 + yy * DY), 64)});
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        while (!done_c && cyc < 3000) begin
            ready_c = ($urandom_range(0, 3) != 0);
            if (we_c && ready_c) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_extra_write got addr=%0d exp none", addr_c);
                end else begin
                    e = sb_q.pop_front();
                    if (addr_c !== e.addr || data_c !== e.data) begin
                        n_bad++;
                        $display("FAIL frame_write%0d got=%0d/%0d exp=%0d/%0d", n, addr_c, data_c, e.addr, e.data);
                    end
                end
                n++;
            end
            tick();
            cyc++;
        end
        n_cmp++; if (n != 12) begin n_bad++; $display("FAIL frame_count got=%0d exp=12", n); end
        n_cmp++; if (done_c !== 1'b1 || busy_c !== 1'b0) begin
            n_bad++; $display("FAIL frame_end got done=%b busy=%b exp done=1 busy=0", done_c, busy_c);
        end
        ready_c = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n_cmp++; if (done_c !== 1'b0 || busy_c !== 1'b1) begin
            n_bad++; $display("FAIL restart got done=%b busy=%b exp done=0 busy=1", done_c, busy_c);
        end
        cyc = 0;
        while (!we_c && cyc < 200) begin tick(); cyc++; end
        n_cmp++; if (we_c !== 1'b1 || addr_c !== 16'd0) begin
            n_bad++; $display("FAIL restart_addr got we=%b addr=%0d exp we=1 addr=0", we_c, addr_c);
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        int cyc = 0;
        do_reset(2);
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (we_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++; $display("FAIL rst_iter got we=%b busy=%b exp 0/0", we_a, busy_a);
        end
        for (int i = 0; i < 200; i++) begin if (we_a) writes++; tick(); end
        n_cmp++; if (writes != 0) begin n_bad++; $display("FAIL rst_iter_writes got=%0d exp=0", writes); end

        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        while (!we_a && cyc < 100) begin tick(); cyc++; end
        n_cmp++; if (we_a !== 1'b1) begin n_bad++; $display("FAIL rst_write_reach got we=%b exp=1", we_a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (we_a !== 1'b0 || addr_a !== 16'd0 || data_a !== 8'd0) begin
            n_bad++; $display("FAIL rst_write got we=%b addr=%0d data=%0d exp 0/0/0", we_a, addr_a, data_a);
        end
        ready_a = 1'b1;
        writes = 0;
        for (int i = 0; i < 200; i++) begin if (we_a) writes++; tick(); end
        n_cmp++; if (writes != 0) begin n_bad++; $display("FAIL rst_write_writes got=%0d exp=0", writes); end
    endtask

    initial begin
        do_reset(3);
        test_reset();
        test_first_write();
        test_backpressure();
        test_zero_c();
        test_frame();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mandel_writer.md
# mandel_writer

Fixed-point Mandelbrot renderer that fills the framebuffer scanned out by the `video` block. It walks every pixel of a `WIDTH`×`HEIGHT` frame in raster order and runs the escape-time iteration z ← z² + c at one iteration per clock. For each pixel it writes an 8-bit colour index into the framebuffer's second write port through a valid/ready handshake. One `start` pulse renders one full frame.

## Interface
- `WIDTH`, 320, pixels per row
- `HEIGHT`, 200, rows; `WIDTH*HEIGHT` ≤ 65536
- `MAXITER`, 64, iteration limit; 1..255
- `X0`, -10240, signed Q4.12 real part of pixel (0,0), i.e. -2.5
- `Y0`, -5120, signed Q4.12 imaginary part of pixel (0,0), i.e. -1.25
- `DX`, 45, signed Q4.12 real step per column
- `DY`, 51, signed Q4.12 imaginary step per row

- `clock`  in  1  single clock, 25 MHz pixel clock domain
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a frame; sampled only in IDLE or DONE
- `busy`  out  1  high from INIT through the last write accept
- `done`  out  1  high after the frame completes, until the next `start` or `reset`
- `w_addr`  out  16  framebuffer byte address, y*WIDTH+x
- `w_data`  out  8  colour index
- `w_we`  out  1  write valid
- `w_ready`  in  1  framebuffer accepts; a transfer occurs on a rising edge with `w_we` && `w_ready`

## Operation
- Arithmetic:
  - All z and c registers are 16-bit signed Q4.12.
  - Products are full 32-bit signed; take bits [27:12]: zx2 = zx·zx, zy2 = zy·zy, zxy = zx·zy.
  - Escape test: zero-extended 17-bit zx2+zy2 ≥ 16384 (|z|² ≥ 4).
  - Overflow cannot occur before escape; no saturation logic.
- State machine:
  - IDLE: outputs idle. `start` → INIT, with x=y=0, addr=0, cx=X0, cy=Y0.
  - INIT: zx=zy=0, iter=0 → ITER.
  - ITER, each cycle:
    - If escape or iter==MAXITER → WRITE, with `w_data` = (iter==MAXITER) ? 0 : iter.
    - Otherwise zx←zx2−zy2+cx, zy←2·zxy+cy, iter←iter+1.
  - WRITE: `w_we`=1, with `w_addr`/`w_data` held stable until accepted. On accept, `w_we` drops next cycle and the pixel advances:
    - Mid-row: x+1, cx+=DX, addr+1 → INIT.
    - Row end (x==WIDTH−1): x=0, cx=X0, cy+=DY, y+1, addr+1 → INIT.
    - Last pixel (x==WIDTH−1, y==HEIGHT−1): → DONE.
  - DONE: `done`=1, `busy`=0. `start` → INIT with all counters reinitialised as in IDLE, and `done` clears on the same edge.
- `start` while busy is ignored.
- `reset` at any point, including mid-WRITE: state→IDLE, `w_we`=0, `busy`=0, `done`=0, `w_addr`=0, `w_data`=0, and all internal registers cleared. No partial write is completed.
- The address is a running counter; there is no multiplier on `w_addr`.

## Timing
- Reset values: `busy`=0, `done`=0, `w_we`=0, `w_addr`=0, `w_data`=0.
- Per-pixel cost with `w_ready` high: 1 INIT + (n+1) ITER + 1 WRITE, where n is the number of updates performed (n ≤ MAXITER).
- Edge numbering: edge 1 samples `start`; `busy` rises after edge 1.
- `w_we` for pixel (0,0) with default params: n=1, so `w_we` is high after edge 4.
- `done` rises on the edge after the final accept; `busy` falls on that same edge.
- Backpressure of any length stalls only WRITE; no state is lost.
- `w_we` is registered; there is no combinational path from `w_ready` to any output.

## Test plan
- Reset: hold `reset` 3 cycles mid-simulation → all outputs 0, state IDLE. `start` then still works.
- Default params, `w_ready`=1, pulse `start`:
  - First write after edge 4: `w_addr`=0, `w_data`=1.
  - Second write: `w_addr`=1.
- Override X0=Y0=DX=DY=0, WIDTH=2, HEIGHT=1, MAXITER=16:
  - Writes at addr 0 and 1, both with data 0.
  - 19 cycles per pixel.
  - `done`=1 exactly 38 cycles after `busy` rises.
- Backpressure: hold `w_ready`=0 for 5 cycles during the first WRITE → `w_we`=1 throughout, `w_addr`=0 and `w_data`=1 stable; accept occurs on the first ready edge; the next pixel's INIT follows.
- Frame completion with WIDTH=4, HEIGHT=3 → exactly 12 accepts at addresses 0..11 in order, then `done`=1 and `busy`=0. A second `start` restarts at addr 0 and clears `done`.
- Reset mid-ITER and mid-WRITE (`w_ready`=0) → `w_we` drops the next cycle, and there are no further writes until a new `start`.
